pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised fetch program counter for the pipelined CPU. It supersedes the plain stall/halt-gated PC register. It adds:
- a configurable width, reset vector and increment;
- a redirect input (branch/jump target) that is buffered when fetch cannot advance;
- a sticky halt state;
- a small circular return-address stack (RAS) for call/return prediction.

It sits at the head of the fetch stage and drives the instruction-cache address.

## Interface
Parameters:
- PC_W, 32, PC and address width in bits.
- RESET_PC, 0, PC value loaded on reset (PC_W bits).
- INC, 4, sequential increment added to the PC.
- RAS_DEPTH, 4, RAS entries; power of two, at least 2.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  instruction fetch for current_pc completed this cycle.
- stall  in  1  hazard stall; PC must hold.
- halt  in  1  halt request from the pipeline.
- redirect_valid  in  1  redirect the PC to redirect_pc.
- redirect_pc  in  PC_W  redirect target.
- ras_push  in  1  push ras_push_pc onto the RAS.
- ras_push_pc  in  PC_W  return address to push.
- ras_pop  in  1  pop the RAS top.
- current_pc  out  PC_W  registered fetch PC.
- pc_plus  out  PC_W  current_pc + INC, combinational.
- halted  out  1  block is in HALTED.
- redirect_pending  out  1  a buffered redirect is waiting.
- ras_top  out  PC_W  top RAS entry; 0 when empty.
- ras_empty  out  1  RAS holds no entries.

## Operation
- States: RUN and HALTED.
  - Reset enters RUN.
  - RUN goes to HALTED on any edge where halt=1.
  - HALTED is left only by reset.
- Advance: adv = ihit & !stall & !halt & (state==RUN).
- Next-PC priority on an adv edge:
  1. same-cycle redirect_valid (redirect_pc);
  2. else the pending redirect;
  3. else pc_plus.
  - Pending is cleared on every adv edge.
- Redirect while not advancing (state RUN, halt=0, adv=0): redirect_pc is written into the pending register and the pending flag is set. A newer redirect overwrites an older one.
- On halt (halt=1 in RUN): PC is not updated, pending is cleared, and any same-cycle redirect is discarded. In HALTED, all inputs except nRST are ignored and the PC is frozen.
- Arithmetic: pc_plus = (current_pc + INC) mod 2^PC_W. There is no alignment check on redirect_pc.
- RAS structure: circular array, top pointer, count 0..RAS_DEPTH. Operations apply in RUN with halt=0, independent of adv.
- RAS push only: entry[top+1] = ras_push_pc, top++, count = min(count+1, RAS_DEPTH). When full, the oldest entry is silently overwritten.
- RAS pop only: if count>0, then top-- and count--. A pop on empty is ignored.
- RAS push and pop together: entry[top] = ras_push_pc; top and count are unchanged. On empty, this acts as a push.
- RAS outputs: ras_top = entry[top] when count>0, else 0. ras_empty = (count==0).

## Timing
- Reset values: current_pc=RESET_PC, pc_plus=RESET_PC+INC, halted=0, redirect_pending=0, ras_top=0, ras_empty=1. All RAS entries are cleared to 0.
- Latency:
  - PC update is one cycle: an adv at edge t makes the new current_pc visible after t.
  - The pending flag is visible the cycle after capture.
  - halted rises the cycle after halt is sampled.
- Buffered redirect: a redirect captured at edge t, followed by the first adv at edge t2>t, gives current_pc=target after t2, unless a newer redirect arrives at t2.
- RAS changes are visible on ras_top/ras_empty the cycle after the operation.
- Reset asserted mid-operation immediately (asynchronously) restores all reset values, including the RAS and the pending redirect.

## Test plan
- Sequential fetch: reset, then ihit=1 for 3 cycles → current_pc goes 0, 4, 8, 12. Hold ihit=0 → PC stays 12.
- Buffered redirect:
  - ihit=0 with redirect_valid=1, redirect_pc=0x100 → redirect_pending=1, PC unchanged.
  - Next cycle, ihit=1 → current_pc=0x100 and redirect_pending=0.
  - Two redirects during a stall (0x200, then 0x300) → PC lands on 0x300.
- Priority: pending=0x100 and same-cycle redirect 0x400 with adv=1 → current_pc=0x400, pending cleared.
- Halt:
  - halt=1 together with redirect_valid=1 → PC frozen, halted=1 next cycle, pending=0.
  - Later ihit/redirect/ras_push pulses → no change on any output.
  - nRST pulse → RESET_PC, halted=0.
- RAS (RAS_DEPTH=4):
  - Push 0x10, 0x20, 0x30, 0x40, 0x50 → ras_top=0x50.
  - Pop 4 times → tops 0x40, 0x30, 0x20, then ras_empty=1 (0x10 was overwritten).
  - A 5th pop → ignored.
  - Simultaneous push 0x60/pop on a one-entry stack → ras_top=0x60, ras_empty=0.
- Wrap and parameters: PC_W=8, RESET_PC=0xFC, INC=4 → one adv gives current_pc=0x00, and the ras_top width is 8.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program counter at the head of the fetch stage.
//
// Holds the fetch PC, advances it by INC when a fetch completes, applies branch/jump
// redirects (buffering one while fetch cannot advance), enters a sticky halt state and
// keeps a small circular return-address stack (RAS) for call/return prediction.
//
// Ports:
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   ihit               fetch of current_pc completed this cycle
//   stall              hazard stall, PC holds
//   halt               halt request; enters HALTED until reset
//   redirect_valid/pc  redirect target (buffered when not advancing)
//   ras_push/push_pc   push a return address
//   ras_pop            pop the RAS top
//   current_pc         registered fetch PC
//   pc_plus            current_pc + INC (combinational)
//   halted             block is in HALTED
//   redirect_pending   a buffered redirect is waiting
//   ras_top            top RAS entry, 0 when empty
//   ras_empty          RAS holds no entries
module pc_sequencer #(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int unsigned     INC       = 4,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            stall,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            ras_push,
  input  logic [PC_W-1:0] ras_push_pc,
  input  logic            ras_pop,
  output logic [PC_W-1:0] current_pc,
  output logic [PC_W-1:0] pc_plus,
  output logic            halted,
  output logic            redirect_pending,
  output logic [PC_W-1:0] ras_top,
  output logic            ras_empty
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pend_pc_q;
  logic             pend_q;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q;
  logic [CNT_W-1:0] cnt_q;

  logic [PTR_W-1:0] top_inc;
  logic [PTR_W-1:0] top_dec;
  logic             adv;
  logic             ras_is_empty;

  assign top_inc      = top_q + PTR_W'(1);
  assign top_dec      = top_q - PTR_W'(1);
  assign ras_is_empty = (cnt_q == '0);
  assign adv          = ihit & ~stall & ~halt & (state_q == StRun);

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_q   <= StRun;
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      top_q     <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StRun: begin
          if (halt) begin
            // Halting drops any buffered or same-cycle redirect and skips RAS updates.
            state_q <= StHalted;
            pend_q  <= 1'b0;
          end else begin
            if (adv) begin
              if (redirect_valid) begin
                pc_q <= redirect_pc;
              end else if (pend_q) begin
                pc_q <= pend_pc_q;
              end else begin
                pc_q <= pc_plus;
              end
              pend_q <= 1'b0;
            end else if (redirect_valid) begin
              // Newest redirect wins while fetch is blocked.
              pend_q    <= 1'b1;
              pend_pc_q <= redirect_pc;
            end

            // RAS operations are independent of adv.
            if (ras_push && (!ras_pop || ras_is_empty)) begin
              // Full stack wraps and overwrites the oldest entry.
              ras_q[top_inc] <= ras_push_pc;
              top_q          <= top_inc;
              if (cnt_q != CNT_FULL) begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else if (ras_push && ras_pop) begin
              ras_q[top_q] <= ras_push_pc;
            end else if (ras_pop && !ras_is_empty) begin
              top_q <= top_dec;
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        default: begin
          // HALTED: frozen until reset.
          state_q <= StHalted;
        end
      endcase
    end
  end

  assign current_pc       = pc_q;
  assign pc_plus          = pc_q + PC_W'(INC);
  assign halted           = (state_q == StHalted);
  assign redirect_pending = pend_q;
  assign ras_top          = ras_is_empty ? '0 : ras_q[top_q];
  assign ras_empty        = ras_is_empty;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, stall, halt, redirect_valid, ras_push, ras_pop;
  logic [31:0] redirect_pc, ras_push_pc;
  logic [31:0] current_pc, pc_plus, ras_top;
  logic        halted, redirect_pending, ras_empty;

  // Narrow instance for wrap-around and parameter checks.
  logic       w_ihit, w_push;
  logic [7:0] w_push_pc;
  logic [7:0] w_pc, w_plus, w_ras_top;
  logic       w_halted, w_pend, w_empty;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: RAS as a bounded queue, newest entry at the back.
  logic [31:0] m_pc, m_pend_pc;
  logic        m_pend, m_halted;
  logic [31:0] m_ras[$];

  always #5 CLK = ~CLK;

  pc_sequencer dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .ihit             (ihit),
    .stall            (stall),
    .halt             (halt),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .ras_push         (ras_push),
    .ras_push_pc      (ras_push_pc),
    .ras_pop          (ras_pop),
    .current_pc       (current_pc),
    .pc_plus          (pc_plus),
    .halted           (halted),
    .redirect_pending (redirect_pending),
    .ras_top          (ras_top),
    .ras_empty        (ras_empty)
  );

  pc_sequencer #(
    .PC_W      (8),
    .RESET_PC  (8'hFC),
    .INC       (4),
    .RAS_DEPTH (4)
  ) dut_w (
    .CLK              (CLK),
    .nRST             (nRST),
    .ihit             (w_ihit),
    .stall            (1'b0),
    .halt             (1'b0),
    .redirect_valid   (1'b0),
    .redirect_pc      (8'h00),
    .ras_push         (w_push),
    .ras_push_pc      (w_push_pc),
    .ras_pop          (1'b0),
    .current_pc       (w_pc),
    .pc_plus          (w_plus),
    .halted           (w_halted),
    .redirect_pending (w_pend),
    .ras_top          (w_ras_top),
    .ras_empty        (w_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    ihit = 0; stall = 0; halt = 0; redirect_valid = 0; redirect_pc = '0;
    ras_push = 0; ras_push_pc = '0; ras_pop = 0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pend = 0; m_pend_pc = '0; m_halted = 0;
    m_ras.delete();
  endtask

  task automatic model_step();
    if (m_halted) return;
    if (halt) begin
      m_halted = 1;
      m_pend   = 0;
      return;
    end
    if (ihit && !stall) begin
      m_pc   = redirect_valid ? redirect_pc : (m_pend ? m_pend_pc : m_pc + 32'd4);
      m_pend = 0;
    end else if (redirect_valid) begin
      m_pend    = 1;
      m_pend_pc = redirect_pc;
    end
    if (ras_push && ras_pop && m_ras.size() > 0) begin
      m_ras[m_ras.size()-1] = ras_push_pc;
    end else if (ras_push) begin
      m_ras.push_back(ras_push_pc);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end else if (ras_pop && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
  endtask

  task automatic compare_all(input string ctx);
    logic [31:0] exp_top;
    exp_top = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
    check({ctx, ".pc"},        current_pc,       m_pc);
    check({ctx, ".pc_plus"},   pc_plus,          m_pc + 32'd4);
    check({ctx, ".halted"},    {31'b0, halted},  {31'b0, m_halted});
    check({ctx, ".pending"},   {31'b0, redirect_pending}, {31'b0, m_pend});
    check({ctx, ".ras_top"},   ras_top,          exp_top);
    check({ctx, ".ras_empty"}, {31'b0, ras_empty}, {31'b0, (m_ras.size() == 0)});
  endtask

  // Inputs are applied at the falling edge; outputs compared at the next falling edge.
  task automatic tick(input string ctx);
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all(ctx);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic do_reset();
    idle();
    #2 nRST = 0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge CLK);
    nRST = 1;
  endtask

  logic [31:0] saved_pc;

  initial begin
    idle();
    w_ihit = 0; w_push = 0; w_push_pc = '0;
    nRST = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    compare_all("reset");
    check("rst_pc", current_pc, 32'h0);
    check("rst_empty", {31'b0, ras_empty}, 32'h1);
    check("w_rst_pc", {24'b0, w_pc}, 32'hFC);
    check("w_rst_plus", {24'b0, w_plus}, 32'h00);
    nRST = 1;

    // Wrap on the 8-bit instance.
    @(negedge CLK);
    w_ihit = 1;
    @(negedge CLK);
    w_ihit = 0;
    check("w_wrap_pc", {24'b0, w_pc}, 32'h00);
    check("w_wrap_plus", {24'b0, w_plus}, 32'h04);
    w_push = 1; w_push_pc = 8'hAB;
    @(negedge CLK);
    w_push = 0;
    check("w_ras_top", {24'b0, w_ras_top}, 32'hAB);
    check("w_ras_empty", {31'b0, w_empty}, 32'h0);

    // Sequential fetch.
    for (int i = 1; i <= 3; i++) begin
      idle(); ihit = 1; tick("seq");
      check("seq_pc", current_pc, 32'(4 * i));
    end
    idle(); tick("hold");
    check("hold_pc", current_pc, 32'd12);

    // Buffered redirect.
    idle(); redirect_valid = 1; redirect_pc = 32'h100; tick("buf");
    check("buf_pend", {31'b0, redirect_pending}, 32'h1);
    check("buf_pc", current_pc, 32'd12);
    idle(); ihit = 1; tick("buf_adv");
    check("buf_adv_pc", current_pc, 32'h100);
    check("buf_adv_pend", {31'b0, redirect_pending}, 32'h0);
    idle(); ihit = 1; stall = 1; redirect_valid = 1; redirect_pc = 32'h200; tick("stall1");
    idle(); ihit = 1; stall = 1; redirect_valid = 1; redirect_pc = 32'h300; tick("stall2");
    idle(); ihit = 1; tick("stall_rel");
    check("newest_redirect", current_pc, 32'h300);

    // Same-cycle redirect beats pending.
    idle(); redirect_valid = 1; redirect_pc = 32'h100; tick("prio_cap");
    idle(); ihit = 1; redirect_valid = 1; redirect_pc = 32'h400; tick("prio");
    check("prio_pc", current_pc, 32'h400);
    check("prio_pend", {31'b0, redirect_pending}, 32'h0);

    // RAS overflow and underflow.
    for (int i = 1; i <= 5; i++) begin
      idle(); ras_push = 1; ras_push_pc = 32'(16 * i); tick("push");
    end
    check("ras_full_top", ras_top, 32'h50);
    for (int i = 0; i < 3; i++) begin
      idle(); ras_pop = 1; tick("pop");
      check("ras_pop_top", ras_top, 32'(16 * (4 - i)));
    end
    idle(); ras_pop = 1; tick("pop4");
    check("ras_drained", {31'b0, ras_empty}, 32'h1);
    idle(); ras_pop = 1; tick("pop5");
    check("ras_pop_empty", ras_top, 32'h0);
    idle(); ras_push = 1; ras_push_pc = 32'h70; tick("push1");
    idle(); ras_push = 1; ras_pop = 1; ras_push_pc = 32'h60; tick("pushpop");
    check("ras_pushpop_top", ras_top, 32'h60);
    check("ras_pushpop_empty", {31'b0, ras_empty}, 32'h0);

    // Halt is sticky and drops the same-cycle redirect.
    saved_pc = current_pc;
    idle(); halt = 1; redirect_valid = 1; redirect_pc = 32'h500; tick("halt");
    check("halt_flag", {31'b0, halted}, 32'h1);
    check("halt_pc", current_pc, saved_pc);
    idle(); ihit = 1; redirect_valid = 1; redirect_pc = 32'h600;
    ras_push = 1; ras_push_pc = 32'h77; tick("halted_in");
    check("halted_pc", current_pc, saved_pc);
    check("halted_ras", ras_top, 32'h60);
    do_reset();
    check("post_rst_halted", {31'b0, halted}, 32'h0);
    check("post_rst_pc", current_pc, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        ihit           = ($urandom_range(0, 9) < 6);
        stall          = ($urandom_range(0, 3) == 0);
        halt           = ($urandom_range(0, 59) == 0);
        redirect_valid = ($urandom_range(0, 4) == 0);
        redirect_pc    = $urandom();
        ras_push       = ($urandom_range(0, 3) == 0);
        ras_push_pc    = $urandom();
        ras_pop        = ($urandom_range(0, 3) == 0);
        tick("rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
